// File: rtl/adder_result_collector.sv
// -----------------------------------------------------------------------------
// adder_result_collector
//
// Collects results from a fixed-latency, non-stallable 64-bit adder pipeline.
// A valid bit travels alongside each operand pair. When that bit reaches the
// end of the pipeline, the adder's {carry, sum} is captured into a small
// result FIFO.
//
// If the FIFO is full when a result arrives and nothing is popped at the same
// edge, the result is dropped. The module then records this in a sticky
// overflow flag and in a saturating drop counter.
//
// Parameters
//   LATENCY     adder depth, in clock edges, from operand sample to result
//   DEPTH       result FIFO entries (power of two, 2..16)
//
// Ports
//   clk         single clock; all state updates on its rising edge
//   reset_n     synchronous, active-low reset
//   issue_valid operand pair presented to the adder this cycle
//   sum_in      adder sum output (64 bits)
//   c_in        adder carry-out
//   out_data    head result {carry, sum}; driven to zero while empty
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head when out_valid is high
//   fifo_count  number of entries held
//   overflow    sticky: a result was dropped because the FIFO was full
//   drop_cnt    number of dropped results, saturating at 255
//   clr_ovf     clears overflow and drop_cnt
// -----------------------------------------------------------------------------
module adder_result_collector #(
   parameter int LATENCY = 8,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       issue_valid,
   input  logic [63:0]                sum_in,
   input  logic                       c_in,
   output logic [64:0]                out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt,
   input  logic                       clr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [LATENCY-1:0] vpipe;
   logic [64:0]        mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count_q;
   logic               ovf_q;
   logic [7:0]         drop_q;

   logic arrival;
   logic pop;
   logic push;
   logic drop;

   // Valid shadow of the adder pipeline. It never stalls. Reset empties it,
   // so results issued before reset can never be captured after it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= issue_valid;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vpipe[i] <= vpipe[i-1];
         end
      end
   end

   // A full FIFO still accepts an arriving result when the head is popped at
   // the same edge.
   always_comb begin
      arrival = vpipe[LATENCY-1];
      pop     = (count_q != '0) && out_ready;
      push    = arrival && ((count_q < FULL_CNT) || pop);
      drop    = arrival && !push;
   end

   // Result storage is not reset; entries are only read while they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {c_in, sum_in};
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // If a drop and a clear happen at the same edge, the drop wins: the flag
   // stays set and the counter restarts at one.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (clr_ovf) begin
            drop_q <= 8'd1;
         end else if (drop_q != '1) begin
            drop_q <= drop_q + 8'd1;
         end
      end else if (clr_ovf) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end
   end

   // The outputs depend only on registered state; out_ready does not reach
   // them combinationally.
   always_comb begin
      out_valid  = (count_q != '0);
      fifo_count = count_q;
      overflow   = ovf_q;
      drop_cnt   = drop_q;
      out_data   = out_valid ? mem[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_adder_result_collector.sv
module tb_adder_result_collector;

   localparam int L = 8;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        issue_valid;
   logic [63:0] sum_in;
   logic        c_in;
   logic [64:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  fifo_count;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        clr_ovf;

   adder_result_collector #(.LATENCY(L), .DEPTH(D)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .issue_valid(issue_valid),
      .sum_in     (sum_in),
      .c_in       (c_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: results still inside the adder (due cycle + value), the
   // FIFO contents, and the error bookkeeping.
   int          cyc = 0;
   int          due_q[$];
   logic [64:0] fly_q[$];
   logic [64:0] fifo_q[$];
   bit          m_ovf = 0;
   int          m_drops = 0;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      else
         n_pass++;
   endtask

   // One clock: drive the inputs, let the edge happen, update the model, then
   // compare everything visible 1 ns after the edge.
   task automatic step(input bit iv, input logic [63:0] a, input logic [63:0] b,
                       input bit rdy, input bit clr, input bit rst_n);
      bit          arr;
      bit          pop;
      bit          push;
      logic [64:0] res;
      logic [64:0] garbage;
      garbage = {$urandom, $urandom, $urandom};
      reset_n     = rst_n;
      issue_valid = iv;
      out_ready   = rdy;
      clr_ovf     = clr;
      arr = (due_q.size() > 0) && (due_q[0] == cyc);
      // The adder output is only meaningful when a result is due this cycle.
      res = arr ? fly_q[0] : garbage;
      {c_in, sum_in} = res;
      @(posedge clk);
      if (!rst_n) begin
         due_q.delete(); fly_q.delete(); fifo_q.delete();
         m_ovf = 0; m_drops = 0;
      end else begin
         if (arr) begin
            void'(due_q.pop_front());
            void'(fly_q.pop_front());
         end
         pop  = (fifo_q.size() > 0) && rdy;
         push = arr && ((fifo_q.size() < D) || pop);
         if (pop) void'(fifo_q.pop_front());
         if (push) fifo_q.push_back(res);
         if (arr && !push) begin
            m_ovf = 1;
            m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
         end else if (clr) begin
            m_ovf = 0; m_drops = 0;
         end
         if (iv) begin
            due_q.push_back(cyc + L);
            fly_q.push_back({1'b0, a} + {1'b0, b});
         end
      end
      cyc++;
      #1;
      check("out_valid", 65'(out_valid), 65'(fifo_q.size() != 0));
      check("fifo_count", 65'(fifo_count), 65'(fifo_q.size()));
      check("overflow", 65'(overflow), 65'(m_ovf));
      check("drop_cnt", 65'(drop_cnt), 65'(m_drops));
      check("data_known", 65'($isunknown(out_data)), 65'(0));
      if (fifo_q.size() != 0) check("out_data", out_data, fifo_q[0]);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, '0, '0, rdy, 0, 1);
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit rdy);
      step(1, a, b, rdy, 0, 1);
   endtask

   initial begin
      logic [63:0] ones;
      ones = '1;

      // Reset state
      step(0, '0, '0, 0, 0, 0);
      step(0, '0, '0, 0, 0, 0);
      check("rst_valid", 65'(out_valid), 65'(0));
      check("rst_count", 65'(fifo_count), 65'(0));

      // A single issue becomes visible right after edge E+LATENCY
      issue(64'd1, 64'd2, 0);
      idle(L - 1, 0);
      check("single_early", 65'(out_valid), 65'(0));
      idle(1, 0);
      check("single_valid", 65'(out_valid), 65'(1));
      check("single_data", out_data, 65'h0_0000_0000_0000_0003);
      idle(2, 1);

      // Carry-out goes into bit 64
      issue(ones, ones, 0);
      idle(L, 0);
      check("carry_data", out_data, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
      idle(2, 1);

      // Four back-to-back issues fill the FIFO without overflow
      for (int i = 0; i < 4; i++) issue(64'(i * 16), 64'd5, 0);
      idle(L + 2, 0);
      check("b2b_count", 65'(fifo_count), 65'(4));
      check("b2b_ovf", 65'(overflow), 65'(0));
      idle(5, 1);

      // Six issues into four entries: two drops, then a clear
      for (int i = 0; i < 6; i++) issue(64'(100 + i), 64'd0, 0);
      idle(L + 2, 0);
      check("ovf_count", 65'(fifo_count), 65'(4));
      check("ovf_flag", 65'(overflow), 65'(1));
      check("ovf_drops", 65'(drop_cnt), 65'(2));
      check("ovf_head", out_data, 65'd100);
      step(0, '0, '0, 0, 1, 1);
      check("clr_flag", 65'(overflow), 65'(0));
      check("clr_drops", 65'(drop_cnt), 65'(0));
      idle(5, 1);

      // Full FIFO with a pop on the arrival edge of a fifth result
      for (int k = 0; k <= L + 4; k++)
         step(k < 5, 64'(200 + k), 64'd0, k == L + 4, 0, 1);
      check("fullpop_count", 65'(fifo_count), 65'(4));
      check("fullpop_drops", 65'(drop_cnt), 65'(0));
      check("fullpop_head", out_data, 65'd201);
      idle(5, 1);

      // Reset while results are still inside the adder
      for (int i = 0; i < 3; i++) issue(64'(300 + i), 64'd1, 0);
      idle(4, 0);
      step(0, '0, '0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, '0, '0, 1'($urandom), 0, 1);
      check("rstfly_count", 65'(fifo_count), 65'(0));

      // Randomised traffic, including occasional clears and resets
      for (int i = 0; i < 2000; i++)
         step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0),
              ($urandom_range(0, 300) != 0));

      // Drop counter saturation
      step(0, '0, '0, 0, 0, 0);
      for (int i = 0; i < 300; i++) issue({$urandom, $urandom}, 64'd0, 0);
      idle(L, 0);
      check("sat_drops", 65'(drop_cnt), 65'(255));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_result_collector.md
ADDER_RESULT_COLLECTOR -- requirements
Module: adder_result_collector

Interface
REQ-001 SHALL have parameter LATENCY, default 8: pipeline depth of the upstream 64-bit adder, in clock edges from operand sample to result register.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries (power of two, 2..16).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  in  1  reset, synchronous and active-low; it is sampled only on posedge clk.
REQ-005 issue_valid  in  1  high in the cycle the upstream presents a valid operand pair to the adder.
REQ-006 sum_in  in  64  adder sum output.
REQ-007 c_in  in  1  adder carry-out.
REQ-008 out_data  out  65  head result {carry, sum[63:0]}.
REQ-009 out_valid  out  1  FIFO non-empty.
REQ-010 out_ready  in  1  consumer accepts head when out_valid=1.
REQ-011 fifo_count  out  $clog2(DEPTH)+1  entries held.
REQ-012 overflow  out  1  sticky: a result was dropped because the FIFO was full.
REQ-013 drop_cnt  out  8  dropped-result count; saturates at 255.
REQ-014 clr_ovf  in  1  clears overflow and drop_cnt.

Function
REQ-015 SHALL hold a LATENCY-bit valid shift register vpipe: vpipe[0] <= issue_valid; vpipe[i] <= vpipe[i-1] on every edge, with no stall.
REQ-016 SHALL define arrival as vpipe[LATENCY-1]=1 at a posedge; the edge then captures {c_in, sum_in}.
REQ-017 Latency SHALL be: issue_valid sampled at edge E -> capture at edge E+LATENCY -> out_valid high after that edge, i.e. LATENCY+1 cycles after issue. There SHALL be no bypass from input to output.
REQ-018 Push SHALL occur on arrival when fifo_count<DEPTH, or when fifo_count=DEPTH and a pop occurs at the same edge.
REQ-019 Pop SHALL occur when out_valid=1 and out_ready=1 at an edge; out_data then advances to the next entry.
REQ-020 Push and pop at the same edge SHALL leave fifo_count unchanged, in both the full and the non-empty cases.
REQ-021 out_ready while empty SHALL be ignored; fifo_count never underflows.
REQ-022 On arrival with the FIFO full and no pop, the result SHALL be discarded, overflow set to 1, and drop_cnt incremented (saturating at 255).
REQ-023 clr_ovf=1 SHALL zero overflow and drop_cnt at that edge. If a drop occurs at the same edge, the drop wins: overflow=1 and drop_cnt=1.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 out_data SHALL be the head entry while out_valid=1 and held stable until popped; while empty its value is don't-care but is driven with no X.
REQ-026 out_valid SHALL equal (fifo_count != 0) and be registered-derived, with no combinational path from out_ready.
REQ-027 sum_in and c_in SHALL be ignored unless an arrival occurs.

Reset
REQ-028 reset_n=0 at an edge SHALL clear vpipe, both pointers, fifo_count, overflow and drop_cnt to 0, so out_valid=0 after that edge.
REQ-029 Reset mid-operation SHALL discard all in-flight and queued results. No result issued before reset is ever pushed after reset, even if the adder still outputs it.
REQ-030 FIFO storage SHALL not require reset.

Verification
REQ-031 Single issue: issue A=1, B=2 at edge 0 -> sum_in=3 at the capture edge -> out_valid rises after edge 8 (LATENCY=8), out_data=65'h0_0000_0000_0000_0003.
REQ-032 Carry: A=B=64'hFFFF_FFFF_FFFF_FFFF -> out_data={1'b1, 64'hFFFF_FFFF_FFFF_FFFE}.
REQ-033 Back-to-back: issue on 4 consecutive edges with out_ready=0 -> fifo_count reaches 4 over 4 consecutive edges; overflow stays 0; results pop in issue order.
REQ-034 Overflow: 6 consecutive issues, out_ready=0, DEPTH=4 -> fifo_count=4, overflow=1, drop_cnt=2; the first 4 results are retained. Then clr_ovf pulse -> overflow=0, drop_cnt=0.
REQ-035 Full plus simultaneous pop: FIFO full and out_ready=1 on an arrival edge -> fifo_count stays 4, head advances, no drop.
REQ-036 Reset in flight: issue 3 results, assert reset_n=0 for 1 edge 4 cycles later -> out_valid stays 0 for the following 20 cycles; fifo_count=0.
